// File: rtl/pattern_seq.sv
// Timed multi-channel bit-pattern sequencer: latches up to DEPTH steps and plays
// one step on w every CLK_DIV clocks, with start/stop/pause, loop and done status.
//
// state | meaning
// IDLE  | w = IDLE_LEVEL, waiting for start with a non-zero len
// RUN   | divider counting, step advances on divider wrap
// PAUSE | divider and w frozen while pause is held
module pattern_seq #(
    parameter int                  CHANNELS   = 1,
    parameter int                  DEPTH      = 8,
    parameter int                  CLK_DIV    = 100000000,
    parameter logic [CHANNELS-1:0] IDLE_LEVEL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         pause,
    input  logic                         loop,
    input  logic [$clog2(DEPTH+1)-1:0]   len,
    input  logic [CHANNELS*DEPTH-1:0]    pattern,
    output logic [CHANNELS-1:0]          w,
    output logic [$clog2(DEPTH)-1:0]     step,
    output logic                         busy,
    output logic                         done
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(DEPTH);
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [LW-1:0] LEN_MAX  = LW'(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    state_t                    state;
    logic [DW-1:0]             div;
    logic [LW-1:0]             len_q;
    logic                      loop_q;
    logic [CHANNELS*DEPTH-1:0] pat_q;
    logic [CHANNELS-1:0]       pat_arr [DEPTH];
    logic [SW-1:0]             step_nx;
    logic                      last_step;

    always_comb begin
        for (int s = 0; s < DEPTH; s++) begin
            pat_arr[s] = pat_q[s*CHANNELS +: CHANNELS];
        end
    end

    assign step_nx   = step + SW'(1);
    assign last_step = (LW'(step) == len_q - LW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            w      <= IDLE_LEVEL;
            step   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            div    <= '0;
            len_q  <= '0;
            loop_q <= 1'b0;
            pat_q  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !stop && len != '0) begin
                        state  <= RUN;
                        pat_q  <= pattern;
                        loop_q <= loop;
                        len_q  <= (len > LEN_MAX) ? LEN_MAX : len;
                        w      <= pattern[CHANNELS-1:0];
                        step   <= '0;
                        div    <= '0;
                        busy   <= 1'b1;
                    end
                end
                RUN, PAUSE: begin
                    if (stop) begin
                        state <= IDLE;
                        w     <= IDLE_LEVEL;
                        step  <= '0;
                        div   <= '0;
                        busy  <= 1'b0;
                    end else if (pause) begin
                        state <= PAUSE;
                    end else begin
                        // Resuming cycle counts as a timer cycle so pause costs exactly its length.
                        state <= RUN;
                        if (div == DIV_LAST) begin
                            div <= '0;
                            if (!last_step) begin
                                step <= step_nx;
                                w    <= pat_arr[step_nx];
                            end else if (loop_q) begin
                                step <= '0;
                                w    <= pat_arr[0];
                            end else begin
                                state <= IDLE;
                                w     <= IDLE_LEVEL;
                                step  <= '0;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else begin
                            div <= div + DW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pattern_seq.sv
// Bench for pattern_seq: directed scenarios plus random control traffic, checked
// against an elapsed-time reference model on two differently configured instances.
module tb_pattern_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst_v, start_v, stop_v, pause_v, loop_v;
    logic [3:0]  len_v [2];
    logic [31:0] pat_v [2];
    logic        w_a;
    logic [3:0]  w_b;
    logic [2:0]  step_a, step_b;
    logic        busy_a, busy_b, done_a, done_b;

    pattern_seq #(.CHANNELS(1), .DEPTH(8), .CLK_DIV(4), .IDLE_LEVEL(1'b0)) u_a (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .stop(stop_v[0]),
        .pause(pause_v[0]), .loop(loop_v[0]), .len(len_v[0]), .pattern(pat_v[0][7:0]),
        .w(w_a), .step(step_a), .busy(busy_a), .done(done_a));

    pattern_seq #(.CHANNELS(4), .DEPTH(8), .CLK_DIV(1), .IDLE_LEVEL(4'h6)) u_b (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .stop(stop_v[1]),
        .pause(pause_v[1]), .loop(loop_v[1]), .len(len_v[1]), .pattern(pat_v[1]),
        .w(w_b), .step(step_b), .busy(busy_b), .done(done_b));

    int vectors = 0;
    int miscompares = 0;
    int tick_n = 0;

    // Reference model: active elapsed cycles t since start; step = (t / CLK_DIV) mod len.
    bit          m_run  [2];
    bit          m_loop [2];
    bit          m_done [2];
    int          m_t    [2];
    int          m_len  [2];
    logic [31:0] m_pat  [2];

    function automatic int dv(int i);   return (i == 0) ? 4 : 1; endfunction
    function automatic int ch(int i);   return (i == 0) ? 1 : 4; endfunction
    function automatic int idle(int i); return (i == 0) ? 0 : 6; endfunction

    task automatic model_step(int i);
        if (rst_v[i]) begin
            m_run[i]  = 0;
            m_done[i] = 0;
        end else if (!m_run[i]) begin
            m_done[i] = 0;
            if (start_v[i] && !stop_v[i] && len_v[i] != 4'd0) begin
                m_run[i]  = 1;
                m_t[i]    = 0;
                m_len[i]  = (len_v[i] > 4'd8) ? 8 : int'(len_v[i]);
                m_loop[i] = loop_v[i];
                m_pat[i]  = pat_v[i];
            end
        end else begin
            m_done[i] = 0;
            if (stop_v[i]) begin
                m_run[i] = 0;
            end else if (!pause_v[i]) begin
                m_t[i]++;
                if (!m_loop[i] && m_t[i] == m_len[i] * dv(i)) begin
                    m_run[i]  = 0;
                    m_done[i] = 1;
                end
            end
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s tick=%0d observed=%0h expected=%0h", tag, tick_n, obs, exp);
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < 2; i++) begin
            int          s;
            logic [31:0] ew;
            logic [31:0] mask;
            mask = (32'd1 << ch(i)) - 32'd1;
            if (m_run[i]) begin
                s  = (m_t[i] / dv(i)) % m_len[i];
                ew = (m_pat[i] >> (s * ch(i))) & mask;
            end else begin
                s  = 0;
                ew = idle(i);
            end
            if (i == 0) begin
                chk("a_w", {31'd0, w_a}, ew);
                chk("a_step", {29'd0, step_a}, s);
                chk("a_busy", {31'd0, busy_a}, {31'd0, m_run[0]});
                chk("a_done", {31'd0, done_a}, {31'd0, m_done[0]});
            end else begin
                chk("b_w", {28'd0, w_b}, ew);
                chk("b_step", {29'd0, step_b}, s);
                chk("b_busy", {31'd0, busy_b}, {31'd0, m_run[1]});
                chk("b_done", {31'd0, done_b}, {31'd0, m_done[1]});
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        tick_n++;
        model_step(0);
        model_step(1);
        #1;
        check_outputs();
    endtask

    task automatic start_run(int i, logic [31:0] pat, logic [3:0] len, logic lp);
        pat_v[i]   = pat;
        len_v[i]   = len;
        loop_v[i]  = lp;
        start_v[i] = 1'b1;
        tick();
        start_v[i] = 1'b0;
    endtask

    // Ticks after the start edge until done is seen; -1 if the budget expires.
    task automatic wait_done(int i, int limit, output int n);
        n = -1;
        for (int k = 1; k <= limit; k++) begin
            tick();
            if (((i == 0) ? done_a : done_b) === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int dcount;
        rst_v = 2'b11; start_v = '0; stop_v = '0; pause_v = '0; loop_v = '0;
        len_v[0] = '0; len_v[1] = '0; pat_v[0] = '0; pat_v[1] = '0;
        for (int i = 0; i < 2; i++) begin
            m_run[i] = 0; m_done[i] = 0; m_t[i] = 0; m_len[i] = 1; m_loop[i] = 0; m_pat[i] = '0;
        end
        tick();
        tick();
        rst_v = 2'b00;
        chk("rst_w_b_idle_level", {28'd0, w_b}, 32'h6);
        chk("rst_busy_a", {31'd0, busy_a}, 32'd0);

        // 1: one-shot, len 7
        start_run(0, 32'h1E, 4'd7, 1'b0);
        chk("t1_first_w", {31'd0, w_a}, 32'd0);
        wait_done(0, 60, n);
        chk("t1_done_latency", n, 32'd28);
        tick();
        chk("t1_done_one_cycle", {31'd0, done_a}, 32'd0);

        // 2: looping, three periods, never done
        start_run(0, 32'h1E, 4'd7, 1'b1);
        dcount = 0;
        for (int k = 0; k < 3 * 28 + 4; k++) begin
            tick();
            if (done_a === 1'b1) dcount++;
        end
        chk("t2_no_done", dcount, 32'd0);
        chk("t2_still_busy", {31'd0, busy_a}, 32'd1);
        stop_v[0] = 1'b1;
        tick();
        stop_v[0] = 1'b0;

        // 3: pause 6 cycles mid step 2 delays the end by 6
        start_run(0, 32'h1E, 4'd7, 1'b0);
        repeat (10) tick();
        chk("t3_in_step2", {29'd0, step_a}, 32'd2);
        pause_v[0] = 1'b1;
        repeat (6) tick();
        pause_v[0] = 1'b0;
        wait_done(0, 60, n);
        chk("t3_done_latency", 16 + n, 32'd34);

        // 4: stop in step 3, reset mid-run, len 0, start with stop
        start_run(0, 32'h1E, 4'd7, 1'b0);
        repeat (13) tick();
        chk("t4_in_step3", {29'd0, step_a}, 32'd3);
        stop_v[0] = 1'b1;
        tick();
        stop_v[0] = 1'b0;
        chk("t4_stop_busy", {31'd0, busy_a}, 32'd0);
        chk("t4_stop_step", {29'd0, step_a}, 32'd0);
        tick();
        chk("t4_stop_no_done", {31'd0, done_a}, 32'd0);
        start_run(1, 32'h1234_5678, 4'd8, 1'b1);
        repeat (5) tick();
        rst_v[1] = 1'b1;
        tick();
        rst_v[1] = 1'b0;
        chk("t4_rst_w", {28'd0, w_b}, 32'h6);
        chk("t4_rst_busy", {31'd0, busy_b}, 32'd0);
        len_v[0] = 4'd0; start_v[0] = 1'b1;
        repeat (3) tick();
        chk("t4_len0_busy", {31'd0, busy_a}, 32'd0);
        len_v[0] = 4'd5; stop_v[0] = 1'b1;
        tick();
        chk("t4_start_stop_busy", {31'd0, busy_a}, 32'd0);
        start_v[0] = 1'b0; stop_v[0] = 1'b0;

        // 5: 4 channels, one step per clock, then clamp of len 9
        start_run(1, 32'h0000_0F5A, 4'd3, 1'b0);
        chk("t5_w0", {28'd0, w_b}, 32'hA);
        tick();
        chk("t5_w1", {28'd0, w_b}, 32'h5);
        tick();
        chk("t5_w2", {28'd0, w_b}, 32'hF);
        tick();
        chk("t5_idle", {28'd0, w_b}, 32'h6);
        chk("t5_done", {31'd0, done_b}, 32'd1);
        start_run(1, $urandom, 4'd9, 1'b0);
        wait_done(1, 30, n);
        chk("t5_len9_clamp", n, 32'd8);

        // Random control traffic on both instances
        for (int k = 0; k < 4000; k++) begin
            for (int i = 0; i < 2; i++) begin
                rst_v[i]   = ($urandom_range(399) == 0);
                start_v[i] = ($urandom_range(5) == 0);
                stop_v[i]  = ($urandom_range(59) == 0);
                if ($urandom_range(7) == 0) pause_v[i] = ~pause_v[i];
                loop_v[i]  = $urandom_range(1);
                len_v[i]   = 4'($urandom_range(10));
                pat_v[i]   = $urandom;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
